// File: rtl/vid_mem_pkg.sv
// Shared types and constants for the video memory responder.
package vid_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } resp_state_t;

  localparam int VID_ADDR_W = 17;
  localparam int VID_DATA_W = 8;
  localparam int PIX_DIV    = 4;
  // Four pixel strobes of clk_sys time, less the cycle spent capturing the address.
  localparam int VID_DEADLINE = 4 * PIX_DIV - 1;

endpackage

// File: rtl/vid_mem_responder.sv
// Turns each new video address into a req/ack read on the shared video RAM path,
// holds the returned byte, and flags/counts fetches that miss the sampling window.
module vid_mem_responder
  import vid_mem_pkg::*;
#(
  parameter int ADDR_W   = VID_ADDR_W,
  parameter int DATA_W   = VID_DATA_W,
  parameter int DEADLINE = VID_DEADLINE
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pix_stb,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_din,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              late,
  output logic [7:0]        late_count,
  output resp_state_t       state_dbg
);

  localparam int CNT_W = $clog2(DEADLINE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEADLINE);

  // Handshake: mem_req rises with mem_addr and both hold until a cycle with
  // mem_ack=1, which also carries mem_data; mem_ack with no request is ignored.
  resp_state_t       state_q, state_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              first_q, first_d;
  logic              pend_valid_q, pend_valid_d;
  logic              late_q, late_d;
  logic [7:0]        late_cnt_q, late_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fetch_needed;

  assign fetch_needed = pix_stb && (first_q || (vid_addr != last_addr_q));

  always_comb begin
    state_d      = state_q;
    din_d        = din_q;
    mem_addr_d   = mem_addr_q;
    last_addr_d  = last_addr_q;
    pend_addr_d  = pend_addr_q;
    first_d      = first_q;
    pend_valid_d = pend_valid_q;
    late_d       = late_q;
    late_cnt_d   = late_cnt_q;
    cnt_d        = cnt_q;

    if (pix_stb) begin
      last_addr_d = vid_addr;
      first_d     = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (fetch_needed) begin
          state_d    = REQ;
          mem_addr_d = vid_addr;
          cnt_d      = '0;
          late_d     = 1'b0;
        end
      end
      REQ: begin
        if (mem_ack) begin
          din_d = mem_data;
          // A capture in the ack cycle is newer than any pending address.
          if (fetch_needed) begin
            mem_addr_d   = vid_addr;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
            late_d       = 1'b0;
          end else if (pend_valid_q) begin
            mem_addr_d   = pend_addr_q;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
            late_d       = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX - 1'b1) begin
              late_d = 1'b1;
              if (late_cnt_q != 8'hFF) late_cnt_d = late_cnt_q + 8'd1;
            end
          end
          if (fetch_needed) begin
            pend_addr_d  = vid_addr;
            pend_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state_q      <= IDLE;
      din_q        <= '0;
      mem_addr_q   <= '0;
      last_addr_q  <= '0;
      pend_addr_q  <= '0;
      first_q      <= 1'b1;
      pend_valid_q <= 1'b0;
      late_q       <= 1'b0;
      late_cnt_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      mem_addr_q   <= mem_addr_d;
      last_addr_q  <= last_addr_d;
      pend_addr_q  <= pend_addr_d;
      first_q      <= first_d;
      pend_valid_q <= pend_valid_d;
      late_q       <= late_d;
      late_cnt_q   <= late_cnt_d;
      cnt_q        <= cnt_d;
    end
  end

  assign vid_din    = din_q;
  assign mem_req    = (state_q == REQ);
  assign mem_addr   = mem_addr_q;
  assign busy       = (state_q == REQ) | pend_valid_q;
  assign late       = late_q;
  assign late_count = late_cnt_q;
  assign state_dbg  = state_q;

endmodule
